fetch_pc_gen: RTL and testbench

//  Next-PC generator at the front of the fetch stage; sits directly upstream of btb.

---
 rtl/fetch_pc_gen.sv | 127 ++++++++++++
 tb/tb_fetch_pc_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Next-PC generator at the front of fetch. Holds the architectural fetch PC,
// presents it to the BTB for a same-cycle lookup and issues one I-cache
// request per cycle over an active-low req/ack handshake. Next-PC priority is
// commit redirect > BTB prediction > sequential.
module fetch_pc_gen #(
  parameter int              ADDR       = 32,
  parameter int              INST_BYTES = 4,
  parameter logic [ADDR-1:0] RESET_VEC  = '0
) (
  input  logic            clk,
  input  logic            reset_,
  output logic [ADDR-1:0] pc,
  input  logic            btb_hit,
  input  logic [ADDR-1:0] btb_addr,
  input  logic            stall_,
  input  logic            redirect_,
  input  logic [ADDR-1:0] redirect_addr,
  output logic            fetch_req_,
  output logic [ADDR-1:0] fetch_addr,
  input  logic            fetch_ack_,
  output logic            fetch_pred_tkn_,
  output logic [ADDR-1:0] fetch_pred_addr
);

  localparam logic EN_  = 1'b0;
  localparam logic DIS_ = 1'b1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_REDIR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR-1:0] r_pc;
  logic [ADDR-1:0] w_pc_nxt;
  logic [ADDR-1:0] r_lat_addr;
  logic [ADDR-1:0] w_lat_addr_nxt;
  logic            r_lat_tkn_;
  logic            w_lat_tkn_nxt_;
  logic [ADDR-1:0] w_seq_addr;
  logic [ADDR-1:0] w_live_addr;
  logic            w_live_tkn_;
  logic [ADDR-1:0] w_align_mask;

  // Sequential successor wraps modulo 2^ADDR; redirect targets are aligned
  // down to an instruction boundary.
  assign w_seq_addr   = r_pc + ADDR'(INST_BYTES);
  assign w_live_addr  = btb_hit ? btb_addr : w_seq_addr;
  assign w_live_tkn_  = ~btb_hit;
  assign w_align_mask = ~(ADDR'(INST_BYTES) - ADDR'(1));

  assign pc         = r_pc;
  assign fetch_addr = r_pc;

  // State, PC and prediction latches; async active-low reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VEC;
      r_lat_addr <= '0;
      r_lat_tkn_ <= DIS_;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_lat_addr <= w_lat_addr_nxt;
      r_lat_tkn_ <= w_lat_tkn_nxt_;
    end
  end

  // Next-state, next-PC and output selection. The request depends only on
  // state and stall_, never on fetch_ack_; a redirect overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_lat_addr_nxt  = r_lat_addr;
    w_lat_tkn_nxt_  = r_lat_tkn_;
    fetch_req_      = DIS_;
    fetch_pred_tkn_ = r_lat_tkn_;
    fetch_pred_addr = r_lat_addr;

    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        fetch_req_      = stall_ ? EN_ : DIS_;
        fetch_pred_tkn_ = w_live_tkn_;
        fetch_pred_addr = w_live_addr;
        if (stall_) begin
          if (!fetch_ack_) begin
            w_pc_nxt = w_live_addr;
          end else begin
            w_lat_addr_nxt = w_live_addr;
            w_lat_tkn_nxt_ = w_live_tkn_;
            w_state_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        fetch_req_ = EN_;
        if (!fetch_ack_) begin
          w_pc_nxt    = r_lat_addr;
          w_state_nxt = S_REQ;
        end
      end
      S_REDIR: begin
        w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase

    // Applied after the case so that a redirect discards any prediction,
    // including one accepted by a coincident ack.
    if (!redirect_) begin
      w_pc_nxt       = redirect_addr & w_align_mask;
      w_lat_addr_nxt = '0;
      w_lat_tkn_nxt_ = DIS_;
      w_state_nxt    = S_REDIR;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: accepted fetch requests are checked
// against a queue of expected {addr, pred_tkn_, pred_addr} entries, with
// extra point checks on bubbles, stalls, WAIT stability and reset.
module tb_fetch_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  typedef struct {
    logic [31:0] a;
    logic        t;
    logic [31:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_;
  logic [31:0] pc;
  logic        btb_hit;
  logic [31:0] btb_addr;
  logic        stall_;
  logic        redirect_;
  logic [31:0] redirect_addr;
  logic        fetch_req_;
  logic [31:0] fetch_addr;
  logic        fetch_ack_;
  logic        fetch_pred_tkn_;
  logic [31:0] fetch_pred_addr;

  int   n_vec   = 0;
  int   n_err   = 0;
  logic exp_acc = 1'b0;
  exp_t sb[$];

  fetch_pc_gen #(
    .ADDR      (32),
    .INST_BYTES(4),
    .RESET_VEC (RV)
  ) dut (
    .clk            (clk),
    .reset_         (reset_),
    .pc             (pc),
    .btb_hit        (btb_hit),
    .btb_addr       (btb_addr),
    .stall_         (stall_),
    .redirect_      (redirect_),
    .redirect_addr  (redirect_addr),
    .fetch_req_     (fetch_req_),
    .fetch_addr     (fetch_addr),
    .fetch_ack_     (fetch_ack_),
    .fetch_pred_tkn_(fetch_pred_tkn_),
    .fetch_pred_addr(fetch_pred_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic hit, input logic [31:0] baddr, input logic st,
                     input logic rd, input logic [31:0] raddr, input logic ack);
    btb_hit       = hit;
    btb_addr      = baddr;
    stall_        = st;
    redirect_     = rd;
    redirect_addr = raddr;
    fetch_ack_    = ack;
  endtask

  task automatic expect_acc(input logic [31:0] a, input logic t, input logic [31:0] p);
    exp_t e;
    e.a = a;
    e.t = t;
    e.p = p;
    sb.push_back(e);
    exp_acc = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle; an accepted request must match the queue head.
  task automatic smp();
    logic acc;
    exp_t e;
    @(negedge clk);
    acc = reset_ && !fetch_req_ && !fetch_ack_;
    chk("handshake", 32'(acc), 32'(exp_acc));
    if (acc && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_addr", fetch_addr, e.a);
      chk("sb_pred_tkn_", 32'(fetch_pred_tkn_), 32'(e.t));
      chk("sb_pred_addr", fetch_pred_addr, e.p);
    end
    exp_acc = 1'b0;
  endtask

  initial begin
    reset_ = 1'b0;
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    smp();
    chk("rst_req_", 32'(fetch_req_), 32'h1);
    chk("rst_tkn_", 32'(fetch_pred_tkn_), 32'h1);
    chk("rst_paddr", fetch_pred_addr, 32'h0);
    chk("rst_addr", fetch_addr, RV);

    // Reset release: one bubble, then sequential fetch at full rate.
    nxt();
    reset_ = 1'b1;
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    smp();
    chk("boot_bubble", 32'(fetch_req_), 32'h1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      expect_acc(RV + 32'(4 * i), 1'b1, RV + 32'(4 * i + 4));
      smp();
    end

    // Redirect to 0xdeadbe74, then BTB hit there.
    nxt();
    drv(1'b0, '0, 1'b1, 1'b0, 32'hdeadbe74, 1'b1);
    smp();
    chk("req_before_redir", 32'(fetch_req_), 32'h0);
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);
    smp();
    chk("redir_bubble", 32'(fetch_req_), 32'h1);
    chk("redir_addr", fetch_addr, 32'hdeadbe74);
    nxt();
    drv(1'b1, 32'hcafecafc, 1'b1, 1'b1, '0, 1'b0);
    expect_acc(32'hdeadbe74, 1'b0, 32'hcafecafc);
    smp();

    // Ack withheld: REQ cycle latches the prediction, WAIT holds it.
    nxt();
    drv(1'b0, 32'h12345678, 1'b1, 1'b1, '0, 1'b1);
    smp();
    chk("btb_target_addr", fetch_addr, 32'hcafecafc);
    chk("noack_paddr", fetch_pred_addr, 32'hcafecb00);
    for (int i = 0; i < 3; i++) begin
      nxt();
      drv((i % 2) == 0, 32'h12345678, (i == 1) ? 1'b0 : 1'b1, 1'b1, '0, 1'b1);
      smp();
      chk("wait_req_", 32'(fetch_req_), 32'h0);
      chk("wait_addr", fetch_addr, 32'hcafecafc);
      chk("wait_tkn_", 32'(fetch_pred_tkn_), 32'h1);
      chk("wait_paddr", fetch_pred_addr, 32'hcafecb00);
    end
    nxt();
    drv(1'b1, 32'h12345678, 1'b1, 1'b1, '0, 1'b0);
    expect_acc(32'hcafecafc, 1'b1, 32'hcafecb00);
    smp();

    // Stall in REQ: no request, PC held.
    for (int i = 0; i < 2; i++) begin
      nxt();
      drv(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
      smp();
      chk("stall_req_", 32'(fetch_req_), 32'h1);
      chk("stall_addr", fetch_addr, 32'hcafecb00);
    end

    // Redirect during WAIT discards the latched prediction.
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);
    smp();
    chk("pre_wait_addr", fetch_addr, 32'hcafecb00);
    nxt();
    drv(1'b0, '0, 1'b1, 1'b0, 32'h00002003, 1'b1);
    smp();
    chk("wait_redir_req_", 32'(fetch_req_), 32'h0);
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    smp();
    chk("redir2_req_", 32'(fetch_req_), 32'h1);
    chk("redir2_tkn_", 32'(fetch_pred_tkn_), 32'h1);
    chk("redir2_paddr", fetch_pred_addr, 32'h0);
    chk("redir2_addr", fetch_addr, 32'h00002000);
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    expect_acc(32'h00002000, 1'b1, 32'h00002004);
    smp();

    // Wrap from the top of the address space.
    nxt();
    drv(1'b0, '0, 1'b1, 1'b0, 32'hfffffffc, 1'b1);
    smp();
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);
    smp();
    chk("top_addr", fetch_addr, 32'hfffffffc);
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    expect_acc(32'hfffffffc, 1'b1, 32'h0);
    smp();
    nxt();
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);
    smp();
    chk("wrap_addr", fetch_addr, 32'h0);

    // Async reset in the middle of WAIT.
    nxt();
    smp();
    chk("wait3_req_", 32'(fetch_req_), 32'h0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_req_", 32'(fetch_req_), 32'h1);
    chk("async_tkn_", 32'(fetch_pred_tkn_), 32'h1);
    chk("async_paddr", fetch_pred_addr, 32'h0);
    chk("async_addr", fetch_addr, RV);
    nxt();
    nxt();
    reset_ = 1'b1;
    drv(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    smp();
    chk("reboot_bubble", 32'(fetch_req_), 32'h1);
    nxt();
    expect_acc(RV, 1'b1, RV + 32'h4);
    smp();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
